// File: rtl/dac_seg_pkg.sv
// Shared types and constants for the DAC segment encoder: code split widths,
// FSM state encoding and the registered output bundle.
package dac_seg_pkg;

    localparam int CODE_W   = 12;
    localparam int NBIN     = 7;
    localparam int NTHERM   = 17;
    localparam int CODE_MAX = (NTHERM + 1) * (2 ** NBIN) - 1;
    localparam int K_W      = CODE_W - NBIN;       // unit count 0..NTHERM
    localparam int P_W      = $clog2(NTHERM);      // rotation pointer 0..NTHERM-1

    typedef enum logic [1:0] {OFF, WAKE, ACTIVE, DRAIN} state_t;

    // What the output registers load on the coming edge.
    typedef enum logic [1:0] {OUT_OFF, OUT_ZERO, OUT_RUN} out_mode_t;

    typedef struct packed {
        logic [NBIN-1:0]   datain;
        logic [NBIN-1:0]   datainb;
        logic [NTHERM-1:0] datatherm;
        logic [NTHERM-1:0] datathermb;
    } out_bundle_t;

    // Zero code as seen by the powered driver: data low, complements high.
    function automatic out_bundle_t zero_code();
        out_bundle_t b;
        b.datain     = '0;
        b.datainb    = '1;
        b.datatherm  = '0;
        b.datathermb = '1;
        return b;
    endfunction

endpackage

// File: rtl/therm_rotator.sv
// Combinational thermometer encoder: k units starting at pointer p (wrapping
// modulo NTHERM) when DEM is on, bottom-aligned otherwise; also the next pointer.
module therm_rotator
    import dac_seg_pkg::*;
(
    input  logic [K_W-1:0]    k,
    input  logic [P_W-1:0]    ptr,
    input  logic              dem,
    output logic [NTHERM-1:0] therm,
    output logic [P_W-1:0]    ptr_next
);

    logic [NTHERM-1:0] base;
    logic [NTHERM-1:0] rotated;
    logic [P_W:0]      sum;
    logic [P_W:0]      idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        base     = '0;
        rotated  = '0;
        idx      = '0;
        therm    = '0;
        ptr_next = ptr;

        for (int i = 0; i < NTHERM; i++) begin
            base[i] = (K_W'(i) < k);
        end

        // Rotate left by ptr: unit i takes base bit (i - ptr) mod NTHERM.
        for (int i = 0; i < NTHERM; i++) begin
            idx = (P_W + 1)'(i + NTHERM) - {1'b0, ptr};
            if (idx >= (P_W + 1)'(NTHERM)) begin
                idx = idx - (P_W + 1)'(NTHERM);
            end
            rotated[i] = base[idx[P_W-1:0]];
        end

        // ptr + k never exceeds 2*NTHERM-1, so one conditional subtract suffices;
        // k = NTHERM lands back on ptr.
        sum = {1'b0, ptr} + {1'b0, k};
        if (dem) begin
            therm    = rotated;
            ptr_next = (sum >= (P_W + 1)'(NTHERM)) ? P_W'(sum - (P_W + 1)'(NTHERM))
                                                   : sum[P_W-1:0];
        end else begin
            therm = base;
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// DAC front end: splits a 12-bit code into binary LSBs and a thermometer MSB
// segment with complements, sequencing driver power through OFF/WAKE/ACTIVE/DRAIN.
module dac_segment_encoder
    import dac_seg_pkg::*;
#(
    parameter int WAKE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dem_en,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [NBIN-1:0]   datain,
    output logic [NBIN-1:0]   datainb,
    output logic [NTHERM-1:0] datatherm,
    output logic [NTHERM-1:0] datathermb,
    output logic              pdb,
    output logic              sat
);

    state_t      state, next_state;
    out_mode_t   out_mode;
    logic [7:0]  wake_cnt, wake_cnt_next;
    logic [1:0]  drain_step, drain_step_next;

    logic              accept;
    logic              over_range;
    logic [CODE_W-1:0] code_sat;

    logic              s1_valid;
    logic [NBIN-1:0]   s1_lo;
    logic [K_W-1:0]    s1_k;
    logic              s1_sat;

    logic              dem_q;
    logic [P_W-1:0]    ptr, ptr_next;
    logic [NTHERM-1:0] therm_word;
    out_bundle_t       out_q;

    assign accept     = code_valid && code_ready;
    assign over_range = code_in > CODE_W'(CODE_MAX);
    assign code_sat   = over_range ? CODE_W'(CODE_MAX) : code_in;

    always_comb begin
        next_state      = state;
        wake_cnt_next   = wake_cnt;
        drain_step_next = drain_step;
        out_mode        = OUT_OFF;
        case (state)
            OFF: begin
                if (en) begin
                    next_state    = WAKE;
                    wake_cnt_next = 8'(WAKE_CYCLES - 1);
                    out_mode      = OUT_ZERO;
                end
            end
            WAKE: begin
                out_mode = OUT_ZERO;
                if (!en) begin
                    next_state = OFF;
                    out_mode   = OUT_OFF;
                end else if (wake_cnt == 8'd0) begin
                    next_state = ACTIVE;
                end else begin
                    wake_cnt_next = wake_cnt - 8'd1;
                end
            end
            ACTIVE: begin
                out_mode = OUT_RUN;
                if (!en) begin
                    next_state      = DRAIN;
                    drain_step_next = 2'd0;
                end
            end
            DRAIN: begin
                // Finish the last in-flight code, show the zero code, then power down.
                case (drain_step)
                    2'd0: begin
                        out_mode        = OUT_RUN;
                        drain_step_next = 2'd1;
                    end
                    2'd1: begin
                        out_mode        = OUT_ZERO;
                        drain_step_next = 2'd2;
                    end
                    default: begin
                        next_state = OFF;
                        out_mode   = OUT_OFF;
                    end
                endcase
            end
            default: next_state = OFF;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            wake_cnt   <= '0;
            drain_step <= '0;
        end else begin
            state      <= next_state;
            wake_cnt   <= wake_cnt_next;
            drain_step <= drain_step_next;
        end
    end

    therm_rotator u_rot (
        .k        (s1_k),
        .ptr      (ptr),
        .dem      (dem_q),
        .therm    (therm_word),
        .ptr_next (ptr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            sat        <= 1'b0;
            pdb        <= 1'b0;
            code_ready <= 1'b0;
            s1_valid   <= 1'b0;
            s1_lo      <= '0;
            s1_k       <= '0;
            s1_sat     <= 1'b0;
            ptr        <= '0;
            dem_q      <= 1'b0;
        end else begin
            pdb        <= (next_state != OFF);
            code_ready <= (next_state == ACTIVE);
            if (state == OFF) begin
                dem_q <= dem_en;
            end
            case (out_mode)
                OUT_ZERO: begin
                    out_q    <= zero_code();
                    sat      <= 1'b0;
                    s1_valid <= 1'b0;
                end
                OUT_RUN: begin
                    // Stage 1: clip and split the accepted code.
                    s1_valid <= accept;
                    if (accept) begin
                        s1_lo  <= code_sat[NBIN-1:0];
                        s1_k   <= code_sat[CODE_W-1:NBIN];
                        s1_sat <= over_range;
                    end
                    // Stage 2: encode, rotate and register; otherwise hold.
                    if (s1_valid) begin
                        out_q.datain     <= s1_lo;
                        out_q.datainb    <= ~s1_lo;
                        out_q.datatherm  <= therm_word;
                        out_q.datathermb <= ~therm_word;
                        sat              <= s1_sat;
                        ptr              <= ptr_next;
                    end else begin
                        sat <= 1'b0;
                    end
                end
                default: begin
                    out_q    <= '0;
                    sat      <= 1'b0;
                    s1_valid <= 1'b0;
                    ptr      <= '0;
                end
            endcase
        end
    end

    assign datain     = out_q.datain;
    assign datainb    = out_q.datainb;
    assign datatherm  = out_q.datatherm;
    assign datathermb = out_q.datathermb;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the encoder.
module tb_dac_segment_encoder;

    localparam int WAKE_N = 16;
    localparam int CMAX   = 2303;
    localparam int PH_OFF = 0, PH_WAKE = 1, PH_ACTIVE = 2, PH_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dem_en = 1'b0;
    logic        code_valid = 1'b0;
    logic [11:0] code_in = '0;
    logic        code_ready;
    logic [6:0]  datain, datainb;
    logic [16:0] datatherm, datathermb;
    logic        pdb, sat;

    dac_segment_encoder #(.WAKE_CYCLES(WAKE_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dem_en     (dem_en),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .pdb        (pdb),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int          m_phase = PH_OFF;
    int          m_wake_seen = 0;
    int          m_drain_n = 0;
    bit          m_dem = 1'b0;
    int          m_ptr = 0;
    int          edge_no = 0;
    int          q_code[$];
    int          q_due[$];
    logic [6:0]  m_datain = '0, m_datainb = '0;
    logic [16:0] m_therm = '0, m_thermb = '0;
    logic        m_pdb = 1'b0, m_ready = 1'b0, m_sat = 1'b0;

    task automatic set_off();
        m_datain = '0; m_datainb = '0; m_therm = '0; m_thermb = '0;
    endtask

    task automatic set_zero();
        m_datain = '0; m_datainb = 7'h7F; m_therm = '0; m_thermb = 17'h1FFFF;
    endtask

    task automatic go_off();
        m_phase = PH_OFF;
        set_off();
        m_ptr = 0;
        q_code.delete();
        q_due.delete();
    endtask

    task automatic apply_code(input int code);
        int c, k, lo, pos;
        logic [16:0] t;
        c   = (code > CMAX) ? CMAX : code;
        lo  = c % 128;
        k   = c / 128;
        t   = '0;
        for (int i = 0; i < k; i++) begin
            pos = m_dem ? (m_ptr + i) % 17 : i;
            t   = t | (17'd1 << pos);
        end
        if (m_dem) m_ptr = (m_ptr + k) % 17;
        m_sat     = (code > CMAX);
        m_datain  = 7'(lo);
        m_datainb = ~7'(lo);
        m_therm   = t;
        m_thermb  = ~t;
    endtask

    task automatic run_pipe(input bit acc, input int code);
        while (q_due.size() > 0 && q_due[0] == edge_no) begin
            apply_code(q_code.pop_front());
            void'(q_due.pop_front());
        end
        if (acc) begin
            q_code.push_back(code);
            q_due.push_back(edge_no + 1);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit d, input bit v, input int code);
        bit accept;
        edge_no++;
        accept = v && m_ready;
        m_sat  = 1'b0;
        if (r) begin
            go_off();
            m_ready = 1'b0;
            m_pdb   = 1'b0;
            return;
        end
        case (m_phase)
            PH_OFF: begin
                m_dem = d;
                if (e) begin
                    m_phase     = PH_WAKE;
                    m_wake_seen = 0;
                    set_zero();
                end else begin
                    set_off();
                end
            end
            PH_WAKE: begin
                if (!e) go_off();
                else begin
                    m_wake_seen++;
                    if (m_wake_seen == WAKE_N) m_phase = PH_ACTIVE;
                end
            end
            PH_ACTIVE: begin
                run_pipe(accept, code);
                if (!e) begin
                    m_phase   = PH_DRAIN;
                    m_drain_n = 0;
                end
            end
            default: begin
                m_drain_n++;
                if (m_drain_n == 1) run_pipe(1'b0, 0);
                else if (m_drain_n == 2) set_zero();
                else go_off();
            end
        endcase
        m_ready = (m_phase == PH_ACTIVE);
        m_pdb   = (m_phase != PH_OFF);
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit v, input logic [11:0] code);
        @(negedge clk);
        rst = r; en = e; dem_en = d; code_valid = v; code_in = code;
        @(posedge clk);
        model_edge(r, e, d, v, int'(code));
        #1;
        check("m_pdb", pdb, m_pdb);
        check("m_ready", code_ready, m_ready);
        check("m_sat", sat, m_sat);
        check("m_datain", datain, m_datain);
        check("m_datainb", datainb, m_datainb);
        check("m_therm", datatherm, m_therm);
        check("m_thermb", datathermb, m_thermb);
    endtask

    task automatic idle(input bit e, input bit d);
        step(1'b0, e, d, 1'b0, 12'd0);
    endtask

    task automatic send(input int code, input bit e, input bit d);
        step(1'b0, e, d, 1'b1, 12'(code));
    endtask

    task automatic wait_ready(input bit d, input string tag);
        int n = 0;
        while (!code_ready && n < 40) begin
            idle(1'b1, d);
            n++;
        end
        check(tag, code_ready, 1'b1);
    endtask

    task automatic wait_off(input string tag);
        int n = 0;
        while (pdb && n < 10) begin
            idle(1'b0, 1'b0);
            n++;
        end
        check(tag, pdb, 1'b0);
    endtask

    initial begin
        int n;
        bit cur_en;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        check("rst_pdb", pdb, 1'b0);
        check("rst_thermb", datathermb, 17'h0);
        check("rst_ready", code_ready, 1'b0);

        // Wake: pdb one cycle after en, ready after WAKE_N more cycles
        idle(1'b1, 1'b0);
        check("wake_pdb", pdb, 1'b1);
        check("wake_thermb", datathermb, 17'h1FFFF);
        check("wake_datainb", datainb, 7'h7F);
        n = 0;
        while (!code_ready && n < 40) begin
            idle(1'b1, 1'b0);
            n++;
        end
        check("wake_len", n, WAKE_N);

        // DEM off basic code
        send(12'h285, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("c645_datain", datain, 7'h05);
        check("c645_therm", datatherm, 17'h0001F);
        check("c645_thermb", datathermb, 17'h1FFE0);
        check("c645_sat", sat, 1'b0);

        // Saturation boundary
        send(4095, 1'b1, 1'b0);
        send(2303, 1'b1, 1'b0);
        check("c4095_sat", sat, 1'b1);
        check("c4095_datain", datain, 7'h7F);
        check("c4095_therm", datatherm, 17'h1FFFF);
        idle(1'b1, 1'b0);
        check("c2303_sat", sat, 1'b0);
        check("c2303_therm", datatherm, 17'h1FFFF);
        idle(1'b1, 1'b0);
        check("hold_therm", datatherm, 17'h1FFFF);

        // Re-enter with DEM on
        wait_off("off_reach1");
        idle(1'b1, 1'b1);
        wait_ready(1'b1, "dem_ready");
        send(640, 1'b1, 1'b1);  idle(1'b1, 1'b1);
        check("dem_k5a", datatherm, 17'h0001F);
        send(640, 1'b1, 1'b1);  idle(1'b1, 1'b1);
        check("dem_k5b", datatherm, 17'h003E0);
        send(1280, 1'b1, 1'b1); idle(1'b1, 1'b1);
        check("dem_k10", datatherm, 17'h1FC07);
        send(2303, 1'b1, 1'b1); idle(1'b1, 1'b1);
        check("dem_k17", datatherm, 17'h1FFFF);
        send(640, 1'b1, 1'b1);  idle(1'b1, 1'b1);
        check("dem_k5_p3", datatherm, 17'h000F8);

        // Drain with two codes in flight (pointer at 8)
        send(12'h105, 1'b1, 1'b1);
        send(12'h0AA, 1'b0, 1'b1);
        check("drain_ready", code_ready, 1'b0);
        check("drain_c1", datain, 7'h05);
        check("drain_c1_therm", datatherm, 17'h00300);
        idle(1'b0, 1'b1);
        check("drain_c2", datain, 7'h2A);
        check("drain_c2_therm", datatherm, 17'h00400);
        idle(1'b0, 1'b1);
        check("drain_zero", datathermb, 17'h1FFFF);
        check("drain_zero_pdb", pdb, 1'b1);
        idle(1'b0, 1'b1);
        check("drain_off_pdb", pdb, 1'b0);
        check("drain_off_thermb", datathermb, 17'h0);

        // Reset during WAKE
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'd0);
        check("rstw_pdb", pdb, 1'b0);
        check("rstw_thermb", datathermb, 17'h0);

        // Reset in ACTIVE mid-stream, then rotation restarts at 0
        idle(1'b1, 1'b1);
        wait_ready(1'b1, "rsta_ready1");
        send(640, 1'b1, 1'b1);
        send(1280, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'd640);
        check("rsta_pdb", pdb, 1'b0);
        check("rsta_datainb", datainb, 7'h0);
        check("rsta_ready", code_ready, 1'b0);
        idle(1'b1, 1'b1);
        wait_ready(1'b1, "rsta_ready2");
        send(640, 1'b1, 1'b1);  idle(1'b1, 1'b1);
        check("rsta_p0", datatherm, 17'h0001F);

        // Random traffic against the model
        cur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int code;
            int sel;
            if (cur_en) begin
                if ($urandom_range(0, 199) == 0) cur_en = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                cur_en = 1'b1;
            end
            sel = int'($urandom_range(0, 9));
            if (sel < 3)       code = int'($urandom_range(2304, 4095));
            else if (sel == 3) code = 2303 + int'($urandom_range(0, 1));
            else if (sel == 4) code = 0;
            else               code = int'($urandom_range(0, 2303));
            step(($urandom_range(0, 499) == 0), cur_en, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7), 12'(code));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
